// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: request control codes,
// FSM state encoding, default core count and a request-decode helper.
package dmem_pkg;

   localparam int unsigned NUM_CORES_DEFAULT = 16;

   // Address bits at and above this position must be zero for an in-range access.
   localparam int unsigned RANGE_LSB = 8;

   localparam logic [1:0] CTRL_NONE = 2'b00;
   localparam logic [1:0] CTRL_IRAM = 2'b01;
   localparam logic [1:0] CTRL_RD   = 2'b10;
   localparam logic [1:0] CTRL_WR   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Only dram reads and writes compete for the memory port.
   function automatic logic is_request(input logic [1:0] ctrl);
      logic r;
      r = 1'b0;
      case (ctrl)
         CTRL_RD, CTRL_WR:     r = 1'b1;
         CTRL_NONE, CTRL_IRAM: r = 1'b0;
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping past N-1 back to 0.
//   req_i     : request vector, one bit per core
//   ptr_i     : highest-priority index this round
//   gnt_oh_o  : one-hot grant (zero when nothing requested)
//   gnt_idx_o : index of the granted core
//   gnt_vld_o : any request present
module rr_arbiter #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   // Linear scan from the pointer; the first hit wins.
   always_comb begin
      int unsigned c;
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      c         = 0;
      for (int unsigned k = 0; k < N; k++) begin
         c = 32'(ptr_i) + k;
         if (c >= N) c = c - N;
         if (!gnt_vld_o && req_i[IDX_W'(c)]) begin
            gnt_vld_o              = 1'b1;
            gnt_idx_o              = IDX_W'(c);
            gnt_oh_o[IDX_W'(c)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among NUM_CORES cores, one transaction at a time.
//   clock, reset_n          : clock, async active-low reset
//   req_ctrl/addr/wdata     : per-core level-held requests (10 read, 11 write)
//   rsp_done/rsp_err        : per-core completion pulse and out-of-range flag
//   rsp_rdata               : read data, valid with rsp_done on reads
//   mem_ctrl/addr/wdata     : memory command, active only in ISSUE
//   mem_rdata               : memory read data, one cycle after a read command
//   busy, grant_id          : transaction in flight, index of served core
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned NUM_CORES = NUM_CORES_DEFAULT,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [2*NUM_CORES-1:0]      req_ctrl,
   input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
   input  logic [DATA_W*NUM_CORES-1:0] req_wdata,
   output logic [NUM_CORES-1:0]        rsp_done,
   output logic [NUM_CORES-1:0]        rsp_err,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic [1:0]                  mem_ctrl,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy,
   output logic [3:0]                  grant_id
);

   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [NUM_CORES-1:0]   grant_oh_q, grant_oh_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                   mask_q, mask_d;
   logic                   rd_q, rd_d;
   logic                   err_q, err_d;
   logic [1:0]             mem_ctrl_q, mem_ctrl_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic [NUM_CORES-1:0]   rsp_done_q, rsp_done_d;
   logic [NUM_CORES-1:0]   rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic                   busy_q, busy_d;

   logic [1:0]             core_ctrl  [NUM_CORES];
   logic [ADDR_W-1:0]      core_addr  [NUM_CORES];
   logic [DATA_W-1:0]      core_wdata [NUM_CORES];
   logic [NUM_CORES-1:0]   req_vld;
   logic [NUM_CORES-1:0]   arb_req;
   logic [NUM_CORES-1:0]   arb_oh;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_vld;
   logic                   win_oor;

   // Split the flat request buses into per-core fields.
   for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign core_ctrl[g]  = req_ctrl[2*g +: 2];
      assign core_addr[g]  = req_addr[ADDR_W*g +: ADDR_W];
      assign core_wdata[g] = req_wdata[DATA_W*g +: DATA_W];
      assign req_vld[g]    = is_request(core_ctrl[g]);
   end

   // The core completed last cycle still holds its request for a cycle; hide it.
   assign arb_req = req_vld & ~(mask_q ? grant_oh_q : '0);

   rr_arbiter #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i     (arb_req),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (arb_oh),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   assign win_oor = (core_addr[arb_idx] >> RANGE_LSB) != '0;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_oh_d  = grant_oh_q;
      rr_ptr_d    = rr_ptr_q;
      mask_d      = 1'b0;
      rd_d        = rd_q;
      err_d       = err_q;
      mem_ctrl_d  = CTRL_NONE;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_done_d  = '0;
      rsp_err_d   = '0;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            // Winner's fields are captured here so later changes by the core are ignored.
            if (arb_vld) begin
               grant_d     = arb_idx;
               grant_oh_d  = arb_oh;
               rd_d        = (core_ctrl[arb_idx] == CTRL_RD);
               err_d       = win_oor;
               mem_ctrl_d  = win_oor ? CTRL_NONE : core_ctrl[arb_idx];
               mem_addr_d  = core_addr[arb_idx];
               mem_wdata_d = core_wdata[arb_idx];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rd_q && !err_q) begin
               state_d = ST_WAIT;
            end else begin
               rsp_done_d = grant_oh_q;
               rsp_err_d  = err_q ? grant_oh_q : '0;
               state_d    = ST_DONE;
            end
         end
         ST_WAIT: begin
            rsp_rdata_d = mem_rdata;
            rsp_done_d  = grant_oh_q;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            rr_ptr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
            mask_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         grant_oh_q  <= '0;
         rr_ptr_q    <= '0;
         mask_q      <= 1'b0;
         rd_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_ctrl_q  <= CTRL_NONE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_done_q  <= '0;
         rsp_err_q   <= '0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_oh_q  <= grant_oh_d;
         rr_ptr_q    <= rr_ptr_d;
         mask_q      <= mask_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
         mem_ctrl_q  <= mem_ctrl_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_done_q  <= rsp_done_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_done  = rsp_done_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_ctrl  = mem_ctrl_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant_id  = 4'(grant_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized core traffic,
// checked every cycle against a transaction-level schedule model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int N  = 16;
   localparam int AW = 16;
   localparam int DW = 16;

   logic              clock   = 1'b0;
   logic              reset_n = 1'b0;
   logic [2*N-1:0]    req_ctrl;
   logic [AW*N-1:0]   req_addr;
   logic [DW*N-1:0]   req_wdata;
   logic [N-1:0]      rsp_done, rsp_err;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        mem_ctrl;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;
   logic              busy;
   logic [3:0]        grant_id;

   logic [1:0]        pin_ctrl  [N];
   logic [AW-1:0]     pin_addr  [N];
   logic [DW-1:0]     pin_wdata [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_ctrl[2*g +: 2]    = pin_ctrl[g];
      assign req_addr[AW*g +: AW]  = pin_addr[g];
      assign req_wdata[DW*g +: DW] = pin_wdata[g];
   end

   dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_ctrl  (req_ctrl),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_done  (rsp_done),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_ctrl  (mem_ctrl),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clock = ~clock;

   // Registered memory: write on 11, read data one cycle after 10.
   logic [DW-1:0] mem [256] = '{default: '0};
   always @(posedge clock) begin
      if (mem_ctrl == CTRL_WR) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_ctrl == CTRL_RD) mem_rdata <= mem[mem_addr[7:0]];
   end

   // Expected outputs for one cycle.
   typedef struct {
      bit          busy;
      int          gid;
      logic [1:0]  mctl;
      logic [15:0] maddr;
      logic [15:0] mwdata;
      int          done;
      bit          err;
      bit          rchk;
      logic [15:0] rdata;
   } rec_t;

   rec_t          exp_q [$];
   logic [DW-1:0] shadow [256] = '{default: '0};
   int            rr_ptr    = 0;
   int            last_done = -1;
   int            mask_core = -1;
   int            cur_done  = -1;
   bit            cur_idle  = 1'b1;
   int            m_gid     = 0;

   bit            act  [N];
   logic [1:0]    cctl [N];
   logic [AW-1:0] caddr[N];
   logic [DW-1:0] cwd  [N];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
      end
   endtask

   function automatic rec_t blank();
      rec_t r;
      r.busy = 1'b0; r.gid = 0; r.mctl = 2'b00; r.maddr = '0; r.mwdata = '0;
      r.done = -1; r.err = 1'b0; r.rchk = 1'b0; r.rdata = '0;
      return r;
   endfunction

   // Compare DUT outputs against this cycle's expected record.
   task automatic clk_edge();
      rec_t        r;
      logic [31:0] oh;
      @(posedge clock);
      #1;
      cur_idle = (exp_q.size() == 0);
      if (cur_idle) r = blank();
      else          r = exp_q.pop_front();
      mask_core = last_done;
      oh = (r.done >= 0) ? (32'(1) << r.done) : 32'(0);
      chk("busy", 32'(busy), 32'(r.busy));
      chk("mem_ctrl", 32'(mem_ctrl), 32'(r.mctl));
      if (r.mctl != 2'b00) begin
         chk("mem_addr", 32'(mem_addr), 32'(r.maddr));
         chk("mem_wdata", 32'(mem_wdata), 32'(r.mwdata));
      end
      if (r.busy) chk("grant_id", 32'(grant_id), r.gid);
      chk("rsp_done", 32'(rsp_done), oh);
      chk("rsp_err", 32'(rsp_err), r.err ? oh : 32'(0));
      if (r.rchk) chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
      cur_done = r.done;
      if (r.done >= 0) rr_ptr = (r.done + 1) % N;
      last_done = r.done;
   endtask

   // Queue the cycle-by-cycle outcome of serving core w.
   task automatic schedule(input int w);
      rec_t iss, wt, dn;
      bit   oor;
      oor = (caddr[w] >> 8) != '0;
      iss = blank(); iss.busy = 1'b1; iss.gid = w;
      iss.mctl = oor ? CTRL_NONE : cctl[w];
      iss.maddr = caddr[w]; iss.mwdata = cwd[w];
      dn = blank(); dn.busy = 1'b1; dn.gid = w; dn.done = w; dn.err = oor;
      exp_q.push_back(iss);
      if (cctl[w] == CTRL_RD && !oor) begin
         wt = blank(); wt.busy = 1'b1; wt.gid = w;
         exp_q.push_back(wt);
         dn.rchk  = 1'b1;
         dn.rdata = shadow[caddr[w][7:0]];
      end else if (cctl[w] == CTRL_WR && !oor) begin
         shadow[caddr[w][7:0]] = cwd[w];
      end
      exp_q.push_back(dn);
      m_gid = w;
   endtask

   // Drive pins from core state; if the arbiter is idle, decide the next service.
   task automatic settle();
      int c;
      for (int i = 0; i < N; i++) begin
         pin_ctrl[i]  = act[i] ? cctl[i] : CTRL_NONE;
         pin_addr[i]  = caddr[i];
         pin_wdata[i] = cwd[i];
      end
      if (cur_idle) begin
         for (int k = 0; k < N; k++) begin
            c = (rr_ptr + k) % N;
            if (act[c] && cctl[c][1] && c != mask_core) begin
               schedule(c);
               break;
            end
         end
      end
   endtask

   task automatic set_core(input int i, input logic [1:0] ct, input logic [15:0] a, input logic [15:0] d);
      act[i] = 1'b1; cctl[i] = ct; caddr[i] = a; cwd[i] = d;
   endtask

   task automatic auto_cores();
      if (cur_done >= 0) act[cur_done] = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) begin clk_edge(); auto_cores(); settle(); end
   endtask

   task automatic new_req(input int i);
      int p;
      p = $urandom_range(0, 99);
      act[i]  = 1'b1;
      cctl[i] = (p < 15) ? CTRL_IRAM : (p < 55) ? CTRL_RD : CTRL_WR;
      caddr[i] = ($urandom_range(0, 99) < 10) ? AW'($urandom_range(256, 65535))
                                              : AW'($urandom_range(0, 31));
      cwd[i]  = DW'($urandom);
   endtask

   task automatic rand_cores();
      for (int i = 0; i < N; i++) begin
         if (cur_done == i) begin
            act[i] = 1'b0;
            if ($urandom_range(0, 99) < 35) new_req(i);
         end else if (!act[i]) begin
            if ($urandom_range(0, 99) < 6) new_req(i);
         end else if (!(exp_q.size() > 0 && m_gid == i)) begin
            if (!cctl[i][1]) begin
               if ($urandom_range(0, 99) < 15) act[i] = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
               act[i] = 1'b0;
            end
         end
      end
   endtask

   int done_log [$];
   int exp_order [3] = '{15, 0, 7};

   initial begin
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0; cctl[i] = CTRL_NONE; caddr[i] = '0; cwd[i] = '0;
      end
      for (int i = 0; i < N; i++) begin
         pin_ctrl[i] = CTRL_NONE; pin_addr[i] = '0; pin_wdata[i] = '0;
      end

      // Reset values
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_ctrl", 32'(mem_ctrl), 0);
      chk("rst_rsp_done", 32'(rsp_done), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
      settle();
      run(2);

      // Single write by core 3
      clk_edge(); set_core(3, CTRL_WR, 16'h0010, 16'hBEEF); settle();
      clk_edge();
      chk("wr_t1_mem_ctrl", 32'(mem_ctrl), 32'h3);
      chk("wr_t1_mem_addr", 32'(mem_addr), 32'h0010);
      chk("wr_t1_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      chk("wr_t1_grant_id", 32'(grant_id), 3);
      auto_cores(); settle();
      clk_edge();
      chk("wr_t2_done", 32'(rsp_done), 32'h0008);
      auto_cores(); settle();

      // Read-back by core 5
      clk_edge(); set_core(5, CTRL_RD, 16'h0010, 16'h0000); settle();
      clk_edge(); chk("rd_t1_mem_ctrl", 32'(mem_ctrl), 32'h2); auto_cores(); settle();
      clk_edge(); chk("rd_t2_mem_ctrl", 32'(mem_ctrl), 32'h0); auto_cores(); settle();
      clk_edge();
      chk("rd_t3_done", 32'(rsp_done), 32'h0020);
      chk("rd_t3_rdata", 32'(rsp_rdata), 32'hBEEF);
      auto_cores(); settle();

      // Core 7 completes so the pointer moves to 8, then 0/7/15 contend
      clk_edge(); set_core(7, CTRL_WR, 16'h0020, 16'h1234); settle();
      run(2);
      clk_edge();
      set_core(0,  CTRL_WR, 16'h0030, 16'h0A0A);
      set_core(7,  CTRL_WR, 16'h0031, 16'h0707);
      set_core(15, CTRL_WR, 16'h0032, 16'h0F0F);
      settle();
      repeat (12) begin
         clk_edge();
         for (int b = 0; b < N; b++) if (rsp_done[b]) done_log.push_back(b);
         auto_cores(); settle();
      end
      chk("contend_count", 32'(done_log.size()), 3);
      for (int k = 0; k < 3; k++)
         chk("contend_order", (k < done_log.size()) ? 32'(done_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));

      // Out-of-range read by core 2
      clk_edge(); set_core(2, CTRL_RD, 16'h0100, 16'h0000); settle();
      clk_edge();
      chk("oor_t1_mem_ctrl", 32'(mem_ctrl), 0);
      chk("oor_t1_busy", 32'(busy), 1);
      auto_cores(); settle();
      clk_edge();
      chk("oor_t2_done", 32'(rsp_done), 32'h0004);
      chk("oor_t2_err", 32'(rsp_err), 32'h0004);
      auto_cores(); settle();

      // Iram code alone is ignored
      clk_edge(); set_core(1, CTRL_IRAM, 16'h0010, 16'h0000); settle();
      repeat (5) begin
         clk_edge();
         chk("iram_busy", 32'(busy), 0);
         chk("iram_mem_ctrl", 32'(mem_ctrl), 0);
         auto_cores(); settle();
      end

      // Reset while a read sits in WAIT
      clk_edge(); act[1] = 1'b0; set_core(4, CTRL_RD, 16'h0010, 16'h0000); settle();
      clk_edge(); auto_cores(); settle();
      clk_edge();
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(rsp_done), 0);
      chk("mid_rst_err", 32'(rsp_err), 0);
      chk("mid_rst_rdata", 32'(rsp_rdata), 0);
      chk("mid_rst_mem_ctrl", 32'(mem_ctrl), 0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 0);
      chk("mid_rst_mem_wdata", 32'(mem_wdata), 0);
      chk("mid_rst_grant_id", 32'(grant_id), 0);
      exp_q.delete();
      rr_ptr = 0; last_done = -1; cur_done = -1;
      clk_edge(); clk_edge();
      @(negedge clock);
      reset_n = 1'b1;
      settle();
      run(3);
      chk("rerequest_done", 32'(rsp_done), 32'h0010);
      chk("rerequest_rdata", 32'(rsp_rdata), 32'hBEEF);

      // Randomized traffic
      repeat (3000) begin
         clk_edge(); rand_cores(); settle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 16, number of requesting cores.
REQ-002 SHALL have parameter ADDR_W, default 16, request address width.
REQ-003 SHALL have parameter DATA_W, default 16, data width.
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_ctrl  input  2*NUM_CORES  per-core control: 00 none, 01 iram read, 10 dram read, 11 dram write.
REQ-007 SHALL have port req_addr  input  ADDR_W*NUM_CORES  per-core address.
REQ-008 SHALL have port req_wdata  input  DATA_W*NUM_CORES  per-core write data.
REQ-009 SHALL have port rsp_done  output  NUM_CORES  one-cycle completion pulse per core.
REQ-010 SHALL have port rsp_err  output  NUM_CORES  out-of-range flag, valid with rsp_done.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, valid with rsp_done on reads.
REQ-012 SHALL have port mem_ctrl  output  2  memory control, 00 or 10 or 11 only.
REQ-013 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-014 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, registered, valid one cycle after mem_ctrl=10.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port grant_id  output  4  index of the core being served.

Function
REQ-018 Only codes 10 and 11 SHALL count as requests; 00 and 01 SHALL be ignored.
REQ-019 Requests SHALL be level-held by the core until its rsp_done pulse.
REQ-020 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: with any valid request, SHALL pick a winner round-robin from rr_ptr upward (wrapping), register grant_id, and go to ISSUE; otherwise stay in IDLE.
REQ-022 ISSUE (one cycle): SHALL drive mem_ctrl, mem_addr, mem_wdata from the granted core; read goes to WAIT, write goes to DONE.
REQ-023 WAIT (one cycle): mem_ctrl SHALL be 00; mem_rdata SHALL be captured into rsp_rdata at the end of the cycle; next state DONE.
REQ-024 DONE (one cycle): rsp_done[grant_id] SHALL be 1; rr_ptr SHALL become grant_id+1 mod NUM_CORES; next state IDLE.
REQ-025 Latency from request seen in IDLE at cycle T: write done at T+2, read done at T+3 with rsp_rdata valid.
REQ-026 The core just completed SHALL be masked from arbitration in the IDLE cycle immediately after its DONE.
REQ-027 If req_addr[ADDR_W-1:8] is nonzero, ISSUE SHALL drive mem_ctrl=00, skip WAIT, and assert rsp_err with rsp_done in DONE.
REQ-028 mem_ctrl SHALL be 00 in all states except ISSUE.
REQ-029 Simultaneous requests SHALL be served one per transaction with no starvation; worst-case wait is (NUM_CORES-1) transactions.
REQ-030 A request withdrawn before grant SHALL be dropped silently; a change after grant SHALL be ignored, because values are sampled in ISSUE.

Reset
REQ-031 reset_n low SHALL force, asynchronously: state IDLE, rr_ptr 0, grant_id 0, rsp_done 0, rsp_err 0, rsp_rdata 0, mem_ctrl 00, mem_addr 0, mem_wdata 0, busy 0.
REQ-032 Reset in ISSUE, WAIT or DONE SHALL abort the transaction with no rsp_done; the core SHALL re-request.

Structure
REQ-033 Package dmem_pkg SHALL hold the ctrl codes (CTRL_NONE, CTRL_IRAM, CTRL_RD, CTRL_WR), the FSM state typedef and the default NUM_CORES.
REQ-034 Round-robin selection SHALL be the combinational sub-module rr_arbiter (request vector + pointer -> one-hot grant + index).

Verification
REQ-035 Single write: core 3 ctrl=11, addr 0x0010, data 0xBEEF -> mem_ctrl=11 at T+1, rsp_done[3] at T+2.
REQ-036 Read-back: then core 5 ctrl=10, addr 0x0010 -> rsp_done[5] at T+3 with rsp_rdata=0xBEEF.
REQ-037 Contention: cores 0, 7, 15 write together, rr_ptr=8 -> service order 15, 0, 7.
REQ-038 Out-of-range: core 2 reads addr 0x0100 -> mem_ctrl stays 00, rsp_done[2]=1 and rsp_err[2]=1 at T+2.
REQ-039 Ignored code: core 1 ctrl=01 alone -> busy stays 0, no mem_ctrl activity.
REQ-040 Reset mid-read: reset_n low in WAIT -> all outputs 0 at once, no rsp_done, IDLE after release.
